sram_like_responder: RTL

Responder (slave) end of the sram-like request/response protocol used by the CPU's instruction and data ports. It accepts address-phase requests with `addr_ok`, queues up to two outstanding transactions, and drives a synchronous single-port RAM with one-cycle read latency. It returns in-order `data_ok` responses after a programmable delay. It serves as the memory model behind either CPU port in standalone benches, and as the bridge to on-chip block RAM in the SoC.

---
 rtl/sram_like_responder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sram_like_responder.sv
// sram_like_responder
//   Responder end of the sram-like request/response protocol. Requests are
//   accepted with addr_ok into a 2-entry in-order queue. The head entry is
//   served by a small state machine that waits DELAY cycles, strobes a
//   synchronous single-port RAM for one cycle, and answers with a one-cycle
//   data_ok pulse on the following cycle.
//
// Parameters
//   ADDR_W : RAM word-address width (RAM holds 2^ADDR_W 32-bit words, <= 29)
//   DELAY  : extra wait cycles (0..7) inserted before each RAM access
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   req/wr/size/addr/wdata : request channel (held stable until addr_ok)
//   addr_ok             : request accepted this cycle
//   data_ok/rdata       : response pulse and read word
//   ram_en/ram_wen/ram_addr/ram_wdata : RAM access strobe and payload
//   ram_rdata           : RAM read data, valid the cycle after ram_en
module sram_like_responder #(
  parameter int ADDR_W = 16,
  parameter int DELAY  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } entry_t;

  localparam logic [2:0] DELAY_C = 3'(DELAY);

  // Byte-lane write strobe for a request; illegal size writes nothing.
  function automatic logic [3:0] wr_strobe(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] s;
    case (sz)
      2'd0:    s = 4'b0001 << a;
      2'd1:    s = a[1] ? 4'b1100 : 4'b0011;
      2'd2:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  state_e       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [1:0]   count_q, count_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  entry_t [1:0] fifo_q, fifo_d;

  entry_t       head;
  logic         push, pop, start;
  logic         unused_addr;

  // addr_ok looks only at the registered count, so a full queue refuses
  // requests even in the cycle its head is being popped.
  assign addr_ok = req & ~reset & (count_q < 2'd2);
  assign push    = req & addr_ok;
  assign head    = fifo_q[rd_ptr_q];

  // Address bits above the RAM word range are don't-care.
  assign unused_addr = ^head.addr[31:ADDR_W+2];

  // ---------------------------------------------------------------------------
  // Request queue
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    if (push) fifo_d[wr_ptr_q] = {wr, size, addr, wdata};
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Head-entry state machine and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start     = 1'b0;
    pop       = 1'b0;
    ram_en    = 1'b0;
    ram_wen   = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    data_ok   = 1'b0;
    rdata     = '0;

    case (state_q)
      // A request pushed this cycle already counts, so an empty queue
      // reaches ACCESS one cycle after the accept edge.
      S_IDLE: start = (count_q != 2'd0) | push;

      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_ACCESS;
      end

      S_ACCESS: begin
        ram_en    = 1'b1;
        ram_wen   = head.wr ? wr_strobe(head.size, head.addr[1:0]) : 4'b0000;
        ram_addr  = head.addr[ADDR_W+1:2];
        ram_wdata = head.wdata;
        state_d   = S_RESP;
      end

      S_RESP: begin
        data_ok = 1'b1;
        rdata   = head.wr ? 32'h0 : ram_rdata;
        pop     = 1'b1;
        state_d = S_IDLE;
        // Something stays behind after this pop: the second entry, or a
        // request pushed in this same cycle.
        start   = (count_q > 2'd1) | push;
      end

      default: state_d = S_IDLE;
    endcase

    if (start) begin
      if (DELAY == 0) begin
        state_d = S_ACCESS;
      end else begin
        state_d = S_WAIT;
        cnt_d   = DELAY_C;
      end
    end

    // Nothing leaves the block while reset is held; queued entries are
    // dropped without a response.
    if (reset) begin
      ram_en    = 1'b0;
      ram_wen   = 4'b0000;
      ram_addr  = '0;
      ram_wdata = '0;
      data_ok   = 1'b0;
      rdata     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage needs no reset: count and pointers define validity.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule
